// File: rtl/io_responder_pkg.sv
// Shared constants for the I/O responder: window base, register offsets, control/status bit positions.
package io_responder_pkg;

    localparam logic [15:0] IO_BASE_ADDR_DEF = 16'hFF00;

    typedef enum logic [2:0] {
        OFF_GPIO_OUT = 3'd0,
        OFF_GPIO_IN  = 3'd1,
        OFF_TCOUNT   = 3'd2,
        OFF_TRELOAD  = 3'd3,
        OFF_TCTRL    = 3'd4,
        OFF_STATUS   = 3'd5,
        OFF_RSVD6    = 3'd6,
        OFF_RSVD7    = 3'd7
    } reg_off_e;

    localparam int TCTRL_EN_BIT     = 0;
    localparam int TCTRL_AUTO_BIT   = 1;
    localparam int TCTRL_IRQ_EN_BIT = 2;
    localparam int TCTRL_PS_LSB     = 8;
    localparam int STATUS_TOV_BIT   = 0;

    typedef struct packed {
        logic [7:0] prescale;
        logic       irq_en;
        logic       auto_rld;
        logic       en;
    } tctrl_t;

    // Byte-lane merge for strobed register writes.
    function automatic logic [15:0] merge_bytes(input logic [15:0] old_val,
                                                input logic [15:0] new_val,
                                                input logic        be0,
                                                input logic        be1);
        logic [15:0] r;
        r       = old_val;
        if (be0) r[7:0]  = new_val[7:0];
        if (be1) r[15:8] = new_val[15:8];
        return r;
    endfunction

    function automatic logic [15:0] tctrl_word(input tctrl_t t);
        logic [15:0] w;
        w                   = 16'h0000;
        w[TCTRL_EN_BIT]     = t.en;
        w[TCTRL_AUTO_BIT]   = t.auto_rld;
        w[TCTRL_IRQ_EN_BIT] = t.irq_en;
        w[TCTRL_PS_LSB +: 8] = t.prescale;
        return w;
    endfunction

endpackage

// File: rtl/io_responder_if.sv
// CPU-side bus of the I/O responder; master = CPU bus interface, slave = responder.
interface io_responder_if;
    logic        BUS_RD;
    logic        BUS_WR0;
    logic        BUS_WR1;
    logic [15:0] BUS_ADDR;
    logic [15:0] BUS_WDATA;
    logic [15:0] BUS_RDATA;
    logic        SEL;

    modport master (
        output BUS_RD, BUS_WR0, BUS_WR1, BUS_ADDR, BUS_WDATA,
        input  BUS_RDATA, SEL
    );

    modport slave (
        input  BUS_RD, BUS_WR0, BUS_WR1, BUS_ADDR, BUS_WDATA,
        output BUS_RDATA, SEL
    );
endinterface

// File: rtl/io_timer.sv
// Prescaled down-counter with reload; o_terminal pulses on a zero-count tick not overridden by a count write.
module io_timer
    import io_responder_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_auto,
    input  logic [7:0]  i_prescale,
    input  logic        i_pre_clr,
    input  logic        i_cnt_wr0,
    input  logic        i_cnt_wr1,
    input  logic        i_rld_wr0,
    input  logic        i_rld_wr1,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_tcount,
    output logic [15:0] o_treload,
    output logic        o_terminal
);

    logic [7:0]  r_pre;
    logic [15:0] r_tcount;
    logic [15:0] r_treload;
    logic        w_tick;
    logic        w_cnt_wr;

    assign w_tick     = i_en && (r_pre == i_prescale);
    assign w_cnt_wr   = i_cnt_wr0 | i_cnt_wr1;
    // A count write in the terminal cycle swallows the terminal event entirely.
    assign o_terminal = w_tick && (r_tcount == 16'h0000) && !w_cnt_wr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= 8'h00;
        end else if (w_cnt_wr || i_pre_clr) begin
            r_pre <= 8'h00;
        end else if (i_en) begin
            r_pre <= w_tick ? 8'h00 : r_pre + 8'h01;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tcount <= 16'h0000;
        end else if (w_cnt_wr) begin
            r_tcount <= merge_bytes(r_tcount, i_wdata, i_cnt_wr0, i_cnt_wr1);
        end else if (w_tick) begin
            if (r_tcount != 16'h0000)
                r_tcount <= r_tcount - 16'h0001;
            else if (i_auto)
                r_tcount <= r_treload;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_treload <= 16'h0000;
        end else if (i_rld_wr0 || i_rld_wr1) begin
            r_treload <= merge_bytes(r_treload, i_wdata, i_rld_wr0, i_rld_wr1);
        end
    end

    assign o_tcount  = r_tcount;
    assign o_treload = r_treload;

endmodule

// File: rtl/io_responder.sv
// 16-byte memory-mapped I/O window: GPIO out/in, interval timer, status with read-to-clear overflow flag.
// Reads are combinational; writes take effect on the strobed posedge.
module io_responder
    import io_responder_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = IO_BASE_ADDR_DEF
)(
    input  logic           CLK,
    input  logic           RESET_N,
    io_responder_if.slave  bus,
    input  logic [15:0]    GPIO_IN,
    output logic [15:0]    GPIO_OUT,
    output logic           IRQ
);

    logic        w_sel;
    reg_off_e    w_off;
    logic        w_wr0;
    logic        w_wr1;
    logic        w_unused;

    logic [15:0] r_gpio_out;
    logic [15:0] r_gin_meta;
    logic [15:0] r_gin_sync;
    tctrl_t      r_tctrl;
    logic        r_tov;
    logic        r_rd_prev;

    logic        w_tctrl_wr0;
    logic        w_tctrl_wr1;
    logic        w_pre_clr;
    logic        w_tov_clr;
    logic        w_terminal;
    logic [15:0] w_tcount;
    logic [15:0] w_treload;
    logic [15:0] w_rdata;

    assign w_sel    = (bus.BUS_ADDR[15:4] == BASE_ADDR[15:4]);
    assign w_off    = reg_off_e'(bus.BUS_ADDR[3:1]);
    assign w_wr0    = w_sel & bus.BUS_WR0;
    assign w_wr1    = w_sel & bus.BUS_WR1;
    assign w_unused = bus.BUS_ADDR[0];

    assign w_tctrl_wr0 = w_wr0 && (w_off == OFF_TCTRL);
    assign w_tctrl_wr1 = w_wr1 && (w_off == OFF_TCTRL);
    assign w_pre_clr   = w_tctrl_wr0 && bus.BUS_WDATA[TCTRL_EN_BIT] && !r_tctrl.en;

    // Clear on an explicit write-one or on the first posedge of a held STATUS read.
    assign w_tov_clr = (w_wr0 && (w_off == OFF_STATUS) && bus.BUS_WDATA[STATUS_TOV_BIT]) ||
                       (w_sel && bus.BUS_RD && !r_rd_prev && (w_off == OFF_STATUS));

    io_timer u_timer (
        .i_clk      (CLK),
        .i_rst_n    (RESET_N),
        .i_en       (r_tctrl.en),
        .i_auto     (r_tctrl.auto_rld),
        .i_prescale (r_tctrl.prescale),
        .i_pre_clr  (w_pre_clr),
        .i_cnt_wr0  (w_wr0 && (w_off == OFF_TCOUNT)),
        .i_cnt_wr1  (w_wr1 && (w_off == OFF_TCOUNT)),
        .i_rld_wr0  (w_wr0 && (w_off == OFF_TRELOAD)),
        .i_rld_wr1  (w_wr1 && (w_off == OFF_TRELOAD)),
        .i_wdata    (bus.BUS_WDATA),
        .o_tcount   (w_tcount),
        .o_treload  (w_treload),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_gpio_out <= 16'h0000;
        end else if (w_off == OFF_GPIO_OUT) begin
            r_gpio_out <= merge_bytes(r_gpio_out, bus.BUS_WDATA, w_wr0, w_wr1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_gin_meta <= 16'h0000;
            r_gin_sync <= 16'h0000;
            r_rd_prev  <= 1'b0;
        end else begin
            r_gin_meta <= GPIO_IN;
            r_gin_sync <= r_gin_meta;
            r_rd_prev  <= bus.BUS_RD;
        end
    end

    // One-shot expiry clears EN even if the same cycle writes TCTRL.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tctrl <= '0;
        end else begin
            if (w_tctrl_wr0) begin
                r_tctrl.en       <= bus.BUS_WDATA[TCTRL_EN_BIT];
                r_tctrl.auto_rld <= bus.BUS_WDATA[TCTRL_AUTO_BIT];
                r_tctrl.irq_en   <= bus.BUS_WDATA[TCTRL_IRQ_EN_BIT];
            end
            if (w_tctrl_wr1) begin
                r_tctrl.prescale <= bus.BUS_WDATA[TCTRL_PS_LSB +: 8];
            end
            if (w_terminal && !r_tctrl.auto_rld) begin
                r_tctrl.en <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tov <= 1'b0;
        end else if (w_terminal) begin
            r_tov <= 1'b1;
        end else if (w_tov_clr) begin
            r_tov <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = 16'h0000;
        if (w_sel && bus.BUS_RD) begin
            case (w_off)
                OFF_GPIO_OUT: w_rdata = r_gpio_out;
                OFF_GPIO_IN:  w_rdata = r_gin_sync;
                OFF_TCOUNT:   w_rdata = w_tcount;
                OFF_TRELOAD:  w_rdata = w_treload;
                OFF_TCTRL:    w_rdata = tctrl_word(r_tctrl);
                OFF_STATUS:   w_rdata[STATUS_TOV_BIT] = r_tov;
                default:      w_rdata = 16'h0000;
            endcase
        end
    end

    assign bus.BUS_RDATA = w_rdata;
    assign bus.SEL       = w_sel;
    assign GPIO_OUT      = r_gpio_out;
    assign IRQ           = r_tov & r_tctrl.irq_en;

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter BASE_ADDR, default 16'hFF00, base of the 16-byte I/O window (ADDR[15:4] compare).
REQ-002 CLK  input  1  single system clock; all state on posedge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 BUS_RD  input  1  read strobe from the CPU bus interface; asserted on CLK negedge, held one or more cycles.
REQ-005 BUS_WR0  input  1  low-byte write strobe; high for exactly one posedge per write.
REQ-006 BUS_WR1  input  1  high-byte write strobe; same timing as BUS_WR0.
REQ-007 BUS_ADDR  input  16  byte address; ADDR[3:1] selects the word register, ADDR[0] is ignored.
REQ-008 BUS_WDATA  input  16  write data, already lane-steered: odd-address byte writes arrive on [15:8].
REQ-009 BUS_RDATA  output  16  read data to CPU_DIN mux.
REQ-010 SEL  output  1  high when BUS_ADDR[15:4] == BASE_ADDR[15:4]; drives the external read-data mux.
REQ-011 GPIO_IN  input  16  asynchronous external inputs.
REQ-012 GPIO_OUT  output  16  output port register.
REQ-013 IRQ  output  1  timer interrupt request, level.

Function
REQ-014 Register map (word offset): 0 GPIO_OUT rw; 1 GPIO_IN ro; 2 TCOUNT rw; 3 TRELOAD rw; 4 TCTRL rw (bit0 EN, bit1 AUTO, bit2 IRQ_EN, bits[15:8] PRESCALE); 5 STATUS (bit0 TOV); 6-7 read 0, writes ignored.
REQ-015 Write: at posedge with SEL and BUS_WR0 high, bits [7:0] of the selected register take BUS_WDATA[7:0]; with BUS_WR1 high, bits [15:8] take BUS_WDATA[15:8]; both high = full word.
REQ-016 Writes to ro registers and to TCTRL bits [7:3] are ignored; those bits read 0.
REQ-017 BUS_RDATA SHALL be combinational: selected register when SEL & BUS_RD, else 16'h0000.
REQ-018 GPIO_IN SHALL pass a 2-flop synchronizer; offset 1 reads the synchronized value (2-cycle latency).
REQ-019 Prescaler: 8-bit counter; with EN=1 it counts up each cycle, emits a tick and resets to 0 when equal to PRESCALE (PRESCALE=0 means tick every cycle).
REQ-020 On tick, TCOUNT != 0 decrements by 1; TCOUNT == 0 on tick is terminal: TOV set, then TCOUNT = TRELOAD if AUTO=1, else TCOUNT stays 0 and EN clears.
REQ-021 Write to TCOUNT loads it and resets the prescaler; a same-cycle terminal tick is discarded (write wins, TOV not set).
REQ-022 Writing EN 0->1 resets the prescaler to 0.
REQ-023 TOV clear: byte-0 write with bit0=1 to STATUS, or first posedge of a STATUS read (BUS_RD high, previous-cycle BUS_RD low, SEL, offset 5).
REQ-024 Simultaneous TOV set and clear in one cycle: set wins.
REQ-025 Read of STATUS returns TOV value before the clear takes effect.
REQ-026 IRQ = TOV & IRQ_EN, registered-free combinational from flops.
REQ-027 Strobes while SEL low SHALL have no effect on any state.

Reset
REQ-028 RESET_N low asynchronously clears GPIO_OUT, TCOUNT, TRELOAD, TCTRL, TOV, prescaler, synchronizer and read-edge flops to 0.
REQ-029 During reset BUS_RDATA=0, IRQ=0, GPIO_OUT=0; reset mid-count abandons the count with no TOV.

Structure
REQ-030 Register offsets, TCTRL/STATUS bit positions and BASE_ADDR default SHALL live in the shared constants file.
REQ-031 Prescaler+counter+reload logic SHALL be sub-module io_timer; decode, register bank and STATUS in io_responder.

Verification
REQ-032 Write 16'hA55A to FF00 with WR0&WR1 -> GPIO_OUT=16'hA55A; then WR1 only to FF01 with data 16'h3C00 -> GPIO_OUT=16'h3C5A.
REQ-033 TRELOAD=3, TCOUNT=3, TCTRL=16'h0007 -> TOV after 4 cycles, IRQ=1, TCOUNT reloads 3, repeats every 4 cycles.
REQ-034 TCOUNT=2, TCTRL=16'h0201 (PRESCALE=2, AUTO=0) -> TOV after 9 cycles, EN reads 0, TCOUNT holds 0.
REQ-035 Read FF0A with TOV=1 -> BUS_RDATA=16'h0001 that cycle, TOV=0 next; held RD for 3 cycles with new TOV set in cycle 2 -> TOV remains 1.
REQ-036 Write TCOUNT=5 in the terminal-tick cycle -> TCOUNT=5, TOV unchanged; GPIO_IN step 0->16'hFFFF -> readable after 2 cycles.
REQ-037 Access FE00 with RD/WR -> SEL=0, BUS_RDATA=0, no register changes; RESET_N low mid-count -> all outputs 0 immediately.
